// File: rtl/an_barrett_decoder_pipe.sv
// AN-code decoder: Barrett division of the received codeword by A in a
// three-stage valid pipeline with a global stall and a saturating error counter.
module an_barrett_decoder_pipe #(
  parameter int unsigned CW_W  = 14,
  parameter int unsigned A     = 29,
  parameter int unsigned R_W   = 5,
  parameter int unsigned K     = 15,
  parameter int unsigned M     = 1129,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW_W-1:0]  q,
  output logic [R_W-1:0]   r,
  output logic             error,
  output logic [CW_W-1:0]  receive,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned MW   = $clog2(M + 1);
  localparam int unsigned P_W  = CW_W + MW;
  localparam int unsigned AW   = $clog2(A + 1);
  localparam int unsigned QA_W = CW_W + AW;
  localparam int unsigned RT_W = R_W + 1;

  logic            stall;
  logic            v1, v2;
  logic [CW_W-1:0] cw1, cw2, qe1, qe2;
  logic [RT_W-1:0] rt2;
  logic [CW_W-1:0] qe_next;
  logic [RT_W-1:0] rt_next;
  logic [CW_W-1:0] q_next;
  logic [R_W-1:0]  r_next;

  // Downstream holding a result it has not taken freezes every stage.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    qe_next = CW_W'((P_W'(codeword) * P_W'(M)) >> K);
    rt_next = RT_W'(QA_W'(cw1) - (QA_W'(qe1) * QA_W'(A)));
    q_next  = qe2;
    r_next  = R_W'(rt2);
    // Barrett estimate may be one short; r_tmp < 2A bounds the fix to one step.
    if (rt2 >= RT_W'(A)) begin
      q_next = qe2 + CW_W'(1);
      r_next = R_W'(rt2 - RT_W'(A));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      cw1       <= '0;
      cw2       <= '0;
      qe1       <= '0;
      qe2       <= '0;
      rt2       <= '0;
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      error     <= 1'b0;
      receive   <= '0;
    end else if (!stall) begin
      v1        <= in_valid;
      cw1       <= codeword;
      qe1       <= qe_next;
      v2        <= v1;
      cw2       <= cw1;
      qe2       <= qe1;
      rt2       <= rt_next;
      out_valid <= v2;
      q         <= q_next;
      r         <= r_next;
      error     <= (r_next != '0);
      receive   <= cw2;
    end
  end

  // Counts delivered error results; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && error && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_an_barrett_decoder_pipe.sv
// Self-checking bench for an_barrett_decoder_pipe: vector table, random
// stalled stream against a division model, counter saturation and async reset.
module tb_an_barrett_decoder_pipe;

  localparam int unsigned CW_W = 14;
  localparam int unsigned R_W  = 5;
  localparam int unsigned AC   = 29;

  logic            clk, rst, in_valid, out_ready, err_clr;
  logic [CW_W-1:0] codeword;
  logic            in_ready, out_valid, error;
  logic [CW_W-1:0] q, receive;
  logic [R_W-1:0]  r;
  logic [15:0]     err_cnt;
  logic            in_ready2, out_valid2, error2;
  logic [CW_W-1:0] q2, receive2;
  logic [R_W-1:0]  r2;
  logic [1:0]      err_cnt2;

  int checks   = 0;
  int failures = 0;

  an_barrett_decoder_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .codeword(codeword), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .error(error), .receive(receive),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  an_barrett_decoder_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .codeword(codeword), .out_valid(out_valid2), .out_ready(out_ready),
    .q(q2), .r(r2), .error(error2), .receive(receive2),
    .err_clr(err_clr), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cw;
    int unsigned eq;
    int unsigned er;
    int unsigned ee;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int unsigned cw);
    in_valid = 1'b1;
    codeword = CW_W'(cw);
    step();
    in_valid = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  vec_t vecs[8];
  int unsigned expq[$];
  int unsigned err_m;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0; codeword = '0;
    #2;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_q", 32'(q), 0);
    check("reset_r", 32'(r), 0);
    check("reset_error", 32'(error), 0);
    check("reset_receive", 32'(receive), 0);
    check("reset_err_cnt", 32'(err_cnt), 0);
    step(); step();
    rst = 1'b0;

    // Fixed vectors, including the correction path and the top codeword.
    vecs[0] = '{2900, 100, 0, 0};
    vecs[1] = '{58, 2, 0, 0};
    vecs[2] = '{16383, 564, 27, 1};
    vecs[3] = '{0, 0, 0, 0};
    vecs[4] = '{28, 0, 28, 1};
    vecs[5] = '{29, 1, 0, 0};
    vecs[6] = '{2901, 100, 1, 1};
    vecs[7] = '{57, 1, 28, 1};
    for (int i = 0; i < 8; i++) begin
      send_one(vecs[i].cw);
      step();
      check("latency_not_early", 32'(out_valid), 0);
      step();
      check("vec_out_valid", 32'(out_valid), 1);
      check("vec_q", 32'(q), vecs[i].eq);
      check("vec_r", 32'(r), vecs[i].er);
      check("vec_error", 32'(error), vecs[i].ee);
      check("vec_receive", 32'(receive), vecs[i].cw);
      step();
      check("vec_drained", 32'(out_valid), 0);
    end
    check("vec_err_cnt", 32'(err_cnt), 4);
    check("vec_err_cnt_sat", 32'(err_cnt2), 3);

    // Random stalled stream of 0..1000 against plain division.
    clear_err();
    err_m = 0;
    begin
      int idx = 0;
      int cyc = 0;
      bit held = 1'b0;
      logic [31:0] hq, hr, he, hrc;
      while ((idx <= 1000 || expq.size() != 0) && cyc < 20000) begin
        in_valid  = (idx <= 1000) && ($urandom_range(7) != 0);
        codeword  = CW_W'(idx);
        out_ready = ($urandom_range(3) != 0);
        #1;
        check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (held) begin
          check("stall_valid", 32'(out_valid), 1);
          check("stall_q", 32'(q), hq);
          check("stall_r", 32'(r), hr);
          check("stall_error", 32'(error), he);
          check("stall_receive", 32'(receive), hrc);
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            check("spurious_result", 32'(out_valid), 0);
          end else begin
            int unsigned c;
            c = expq.pop_front();
            check("stream_q", 32'(q), c / AC);
            check("stream_r", 32'(r), c % AC);
            check("stream_error", 32'(error), 32'((c % AC) != 0));
            check("stream_receive", 32'(receive), c);
            if ((c % AC) != 0) err_m++;
          end
        end
        held = out_valid && !out_ready;
        hq = 32'(q); hr = 32'(r); he = 32'(error); hrc = 32'(receive);
        if (in_valid && in_ready) begin
          expq.push_back(idx);
          idx++;
        end
        step();
        cyc++;
      end
      check("stream_complete", 32'(idx > 1000 && expq.size() == 0), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("stream_err_cnt", 32'(err_cnt), err_m);
    check("stream_err_cnt_sat", 32'(err_cnt2), (err_m > 3) ? 3 : err_m);

    // Saturation of the 2-bit counter and clear priority.
    clear_err();
    for (int i = 0; i < 5; i++) begin
      send_one(2901);
      step(); step(); step();
      check("sat_err_cnt2", 32'(err_cnt2), (i + 1 > 3) ? 3 : i + 1);
    end
    check("sat_err_cnt16", 32'(err_cnt), 5);
    send_one(2901);
    step(); step();
    check("clr_out_valid", 32'(out_valid), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_priority", 32'(err_cnt), 0);
    check("clr_priority_sat", 32'(err_cnt2), 0);

    // Asynchronous reset with three results in flight.
    send_one(2901);
    step(); step(); step();
    check("pre_rst_err_cnt", 32'(err_cnt), 1);
    out_ready = 1'b0;
    send_one(290);
    send_one(291);
    send_one(292);
    check("inflight_valid", 32'(out_valid), 1);
    check("inflight_stall", 32'(in_ready), 0);
    #3;
    rst = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 0);
    check("async_err_cnt", 32'(err_cnt), 0);
    check("async_in_ready", 32'(in_ready), 1);
    check("async_q", 32'(q), 0);
    step(); step();
    out_ready = 1'b1;
    #2;
    rst = 1'b0;
    send_one(87);
    step(); step();
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_q", 32'(q), 3);
    check("post_rst_receive", 32'(receive), 87);
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_stale", 32'(out_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
